// File: rtl/traffic_pkg.sv
// Shared types for the traffic sensor conditioner and the light controller it feeds.
package traffic_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESENT = 2'd1,
      HOLD    = 2'd2
   } sensor_state_t;

   typedef enum logic [1:0] {
      GREEN  = 2'd0,
      YELLOW = 2'd1,
      RED    = 2'd2
   } light_t;

endpackage

// File: rtl/traffic_sensor_cond_if.sv
// Detector, clear and conditioned-flag bundle between the sensor block and the light controller.
interface traffic_sensor_cond_if #(
   parameter int CNT_W = 4
);
   logic             det_a;
   logic             det_b;
   logic             clr_a;
   logic             clr_b;
   logic             Ta;
   logic             Tb;
   logic [CNT_W-1:0] cnt_a;
   logic [CNT_W-1:0] cnt_b;
   logic             fault_a;
   logic             fault_b;

   modport master (
      output det_a, det_b, clr_a, clr_b,
      input  Ta, Tb, cnt_a, cnt_b, fault_a, fault_b
   );

   modport slave (
      input  det_a, det_b, clr_a, clr_b,
      output Ta, Tb, cnt_a, cnt_b, fault_a, fault_b
   );
endinterface

// File: rtl/sensor_channel.sv
// One detector channel: 2-flop sync, debounce, IDLE/PRESENT/HOLD FSM, arrival counter.
// Stuck-detector fail-safe is built only when SENSOR_STUCK_DET_EN is defined.
module sensor_channel
   import traffic_pkg::*;
#(
   parameter int DEB_CYCLES   = 4,
   parameter int HOLD_CYCLES  = 8,
   parameter int CNT_W        = 4,
   parameter int STUCK_CYCLES = 1024
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             det,
   input  logic             clr,
   output logic             t,
   output logic [CNT_W-1:0] cnt,
   output logic             fault
);
   localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
   localparam int HOLD_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
   localparam bit NO_HOLD = (HOLD_CYCLES == 0);

   logic [1:0]       sync_reg;
   logic             deb_reg;
   logic [DEB_W-1:0] deb_cnt_reg;
   sensor_state_t    state_reg;
   logic [HOLD_W-1:0] hold_reg;
   logic             t_reg;
   logic [CNT_W-1:0] cnt_reg;

   logic deb_done;
   logic deb_rise;
   logic deb_fall;

   // The debounce decision feeds the FSM in the same edge, so Ta follows deb with no extra cycle.
   assign deb_done = (sync_reg[1] != deb_reg) && (deb_cnt_reg == DEB_W'(DEB_CYCLES - 1));
   assign deb_rise = deb_done && sync_reg[1];
   assign deb_fall = deb_done && !sync_reg[1];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_reg    <= '0;
         deb_reg     <= 1'b0;
         deb_cnt_reg <= '0;
         state_reg   <= IDLE;
         hold_reg    <= '0;
         t_reg       <= 1'b0;
         cnt_reg     <= '0;
      end else begin
         sync_reg <= {sync_reg[0], det};

         if (sync_reg[1] == deb_reg) begin
            deb_cnt_reg <= '0;
         end else if (deb_done) begin
            deb_cnt_reg <= '0;
            deb_reg     <= sync_reg[1];
         end else begin
            deb_cnt_reg <= deb_cnt_reg + 1'b1;
         end

         case (state_reg)
            IDLE: begin
               if (deb_rise) begin
                  state_reg <= PRESENT;
                  t_reg     <= 1'b1;
               end
            end
            PRESENT: begin
               if (deb_fall) begin
                  if (NO_HOLD) begin
                     state_reg <= IDLE;
                     t_reg     <= 1'b0;
                  end else begin
                     state_reg <= HOLD;
                     hold_reg  <= HOLD_W'(HOLD_CYCLES);
                  end
               end
            end
            HOLD: begin
               // A re-arrival wins over an expiring timer so the flag never dips.
               if (deb_rise) begin
                  state_reg <= PRESENT;
               end else if (hold_reg <= HOLD_W'(1)) begin
                  state_reg <= IDLE;
                  hold_reg  <= '0;
                  t_reg     <= 1'b0;
               end else begin
                  hold_reg <= hold_reg - 1'b1;
               end
            end
            default: begin
               state_reg <= IDLE;
               t_reg     <= 1'b0;
            end
         endcase

         if (clr) begin
            cnt_reg <= deb_rise ? CNT_W'(1) : '0;
         end else if (deb_rise && (cnt_reg != {CNT_W{1'b1}})) begin
            cnt_reg <= cnt_reg + 1'b1;
         end
      end
   end

   assign cnt = cnt_reg;

`ifdef SENSOR_STUCK_DET_EN
   localparam int STUCK_W = $clog2(STUCK_CYCLES + 1);

   logic [STUCK_W-1:0] stuck_cnt_reg;
   logic               fault_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stuck_cnt_reg <= '0;
         fault_reg     <= 1'b0;
      end else if (!deb_reg) begin
         stuck_cnt_reg <= '0;
      end else if (!fault_reg) begin
         if (stuck_cnt_reg == STUCK_W'(STUCK_CYCLES - 1)) begin
            fault_reg <= 1'b1;
         end
         stuck_cnt_reg <= stuck_cnt_reg + 1'b1;
      end
   end

   // A latched fault forces presence so the controller keeps serving the road.
   assign fault = fault_reg;
   assign t     = t_reg | fault_reg;
`else
   assign fault = 1'b0;
   assign t     = t_reg;
`endif

endmodule

// File: rtl/traffic_sensor_cond.sv
// Two independent loop-detector conditioners (roads A and B) behind one interface port.
// Optional stuck-detector fail-safe: define SENSOR_STUCK_DET_EN.
module traffic_sensor_cond #(
   parameter int DEB_CYCLES   = 4,
   parameter int HOLD_CYCLES  = 8,
   parameter int CNT_W        = 4,
   parameter int STUCK_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  reset,
   traffic_sensor_cond_if.slave  bus
);
   logic [1:0]       det_vec;
   logic [1:0]       clr_vec;
   logic [1:0]       t_vec;
   logic [1:0]       fault_vec;
   logic [CNT_W-1:0] cnt_arr [2];

   assign det_vec = {bus.det_b, bus.det_a};
   assign clr_vec = {bus.clr_b, bus.clr_a};

   // Index 0 is road A, index 1 is road B.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_ch
         sensor_channel #(
            .DEB_CYCLES   (DEB_CYCLES),
            .HOLD_CYCLES  (HOLD_CYCLES),
            .CNT_W        (CNT_W),
            .STUCK_CYCLES (STUCK_CYCLES)
         ) u_ch (
            .clk   (clk),
            .reset (reset),
            .det   (det_vec[gi]),
            .clr   (clr_vec[gi]),
            .t     (t_vec[gi]),
            .cnt   (cnt_arr[gi]),
            .fault (fault_vec[gi])
         );
      end
   endgenerate

   assign bus.Ta      = t_vec[0];
   assign bus.Tb      = t_vec[1];
   assign bus.cnt_a   = cnt_arr[0];
   assign bus.cnt_b   = cnt_arr[1];
   assign bus.fault_a = fault_vec[0];
   assign bus.fault_b = fault_vec[1];

endmodule

// File: tb/tb_traffic_sensor_cond.sv
// Directed bench for traffic_sensor_cond with default parameters; t is the edge after which det changes.
module tb_traffic_sensor_cond;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int   pass_cnt = 0;
   int   total_cnt = 0;

   traffic_sensor_cond_if #(.CNT_W(4)) bus ();

   traffic_sensor_cond dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Clean arrival: detector high for hi cycles then low for lo cycles.
   task automatic arrive(input bit ch, input int hi, input int lo);
      if (ch) bus.det_b = 1'b1; else bus.det_a = 1'b1;
      tick(hi);
      if (ch) bus.det_b = 1'b0; else bus.det_a = 1'b0;
      tick(lo);
   endtask

   task automatic test_reset;
      bus.det_a = 1'b0; bus.det_b = 1'b0; bus.clr_a = 1'b0; bus.clr_b = 1'b0;
      reset = 1'b0;
      tick(3);
      total_cnt++; if (bus.Ta !== 1'b0) $display("FAIL rst_ta: got %b expected 0", bus.Ta); else pass_cnt++;
      total_cnt++; if (bus.Tb !== 1'b0) $display("FAIL rst_tb: got %b expected 0", bus.Tb); else pass_cnt++;
      total_cnt++; if (bus.cnt_a !== 4'd0) $display("FAIL rst_cnt_a: got %0d expected 0", bus.cnt_a); else pass_cnt++;
      total_cnt++; if (bus.cnt_b !== 4'd0) $display("FAIL rst_cnt_b: got %0d expected 0", bus.cnt_b); else pass_cnt++;
      total_cnt++; if (bus.fault_a !== 1'b0) $display("FAIL rst_fault_a: got %b expected 0", bus.fault_a); else pass_cnt++;
      total_cnt++; if (bus.fault_b !== 1'b0) $display("FAIL rst_fault_b: got %b expected 0", bus.fault_b); else pass_cnt++;
      reset = 1'b1;
      tick(2);
      $display("reset: Ta=%b Tb=%b cnt_a=%0d cnt_b=%0d", bus.Ta, bus.Tb, bus.cnt_a, bus.cnt_b);
   endtask

   task automatic test_bounce;
      bit ta_seen = 1'b0;
      bus.det_a = 1'b1;
      tick(2);
      bus.det_a = 1'b0;
      for (int i = 0; i < 14; i++) begin
         tick(1);
         if (bus.Ta !== 1'b0) ta_seen = 1'b1;
      end
      total_cnt++; if (ta_seen !== 1'b0) $display("FAIL bounce_ta: got Ta high expected Ta low"); else pass_cnt++;
      total_cnt++; if (bus.cnt_a !== 4'd0) $display("FAIL bounce_cnt: got %0d expected 0", bus.cnt_a); else pass_cnt++;
      $display("bounce: Ta=%b cnt_a=%0d", bus.Ta, bus.cnt_a);
   endtask

   task automatic test_clean;
      bus.det_a = 1'b1;                  // t
      tick(5);                           // t+5
      total_cnt++; if (bus.Ta !== 1'b0) $display("FAIL clean_ta_early: got %b expected 0", bus.Ta); else pass_cnt++;
      tick(1);                           // t+6
      total_cnt++; if (bus.Ta !== 1'b1) $display("FAIL clean_ta_rise: got %b expected 1", bus.Ta); else pass_cnt++;
      total_cnt++; if (bus.cnt_a !== 4'd1) $display("FAIL clean_cnt: got %0d expected 1", bus.cnt_a); else pass_cnt++;
      tick(6);                           // t+12
      bus.det_a = 1'b0;
      tick(13);                          // t+25
      total_cnt++; if (bus.Ta !== 1'b1) $display("FAIL clean_ta_hold: got %b expected 1", bus.Ta); else pass_cnt++;
      tick(1);                           // t+26
      total_cnt++; if (bus.Ta !== 1'b0) $display("FAIL clean_ta_fall: got %b expected 0", bus.Ta); else pass_cnt++;
      total_cnt++; if (bus.Tb !== 1'b0 || bus.cnt_b !== 4'd0)
         $display("FAIL clean_b_idle: got Tb=%b cnt_b=%0d expected 0/0", bus.Tb, bus.cnt_b); else pass_cnt++;
      $display("clean: Ta=%b cnt_a=%0d", bus.Ta, bus.cnt_a);
      tick(4);
   endtask

   task automatic test_rearrival;
      bit dropped = 1'b0;
      bus.clr_a = 1'b1;
      tick(1);
      bus.clr_a = 1'b0;
      total_cnt++; if (bus.cnt_a !== 4'd0) $display("FAIL rearr_clr: got %0d expected 0", bus.cnt_a); else pass_cnt++;
      bus.det_a = 1'b1;                  // t
      for (int i = 1; i <= 40; i++) begin
         tick(1);                        // t+i
         if (i >= 6 && i <= 39 && bus.Ta !== 1'b1) dropped = 1'b1;
         if (i == 12) bus.det_a = 1'b0;
         if (i == 16) bus.det_a = 1'b1;
         if (i == 26) bus.det_a = 1'b0;
      end
      total_cnt++; if (dropped !== 1'b0) $display("FAIL rearr_ta_drop: got Ta low during hold expected high"); else pass_cnt++;
      total_cnt++; if (bus.Ta !== 1'b0) $display("FAIL rearr_ta_end: got %b expected 0", bus.Ta); else pass_cnt++;
      total_cnt++; if (bus.cnt_a !== 4'd2) $display("FAIL rearr_cnt: got %0d expected 2", bus.cnt_a); else pass_cnt++;
      $display("rearrival: Ta=%b cnt_a=%0d", bus.Ta, bus.cnt_a);
      tick(4);
   endtask

   task automatic test_saturation;
      bus.clr_a = 1'b1;
      tick(1);
      bus.clr_a = 1'b0;
      for (int i = 0; i < 15; i++) arrive(1'b0, 8, 8);
      total_cnt++; if (bus.cnt_a !== 4'd15) $display("FAIL sat_15: got %0d expected 15", bus.cnt_a); else pass_cnt++;
      for (int i = 0; i < 2; i++) arrive(1'b0, 8, 8);
      total_cnt++; if (bus.cnt_a !== 4'd15) $display("FAIL sat_17: got %0d expected 15", bus.cnt_a); else pass_cnt++;
      // Clear lands on the same edge as the debounced rise.
      bus.det_a = 1'b1;                  // t
      tick(5);
      bus.clr_a = 1'b1;
      tick(1);                           // t+6
      bus.clr_a = 1'b0;
      total_cnt++; if (bus.cnt_a !== 4'd1) $display("FAIL sat_clr_rise: got %0d expected 1", bus.cnt_a); else pass_cnt++;
      bus.det_a = 1'b0;
      tick(20);
      bus.clr_a = 1'b1;
      tick(1);
      bus.clr_a = 1'b0;
      total_cnt++; if (bus.cnt_a !== 4'd0) $display("FAIL sat_clr: got %0d expected 0", bus.cnt_a); else pass_cnt++;
      total_cnt++; if (bus.Tb !== 1'b0 || bus.cnt_b !== 4'd0)
         $display("FAIL sat_b_idle: got Tb=%b cnt_b=%0d expected 0/0", bus.Tb, bus.cnt_b); else pass_cnt++;
      $display("saturation: cnt_a=%0d cnt_b=%0d", bus.cnt_a, bus.cnt_b);
   endtask

   task automatic test_simultaneous;
      bus.det_a = 1'b1; bus.det_b = 1'b1;  // t
      tick(6);
      total_cnt++; if (bus.Ta !== 1'b1 || bus.Tb !== 1'b1)
         $display("FAIL sim_t: got Ta=%b Tb=%b expected 1/1", bus.Ta, bus.Tb); else pass_cnt++;
      total_cnt++; if (bus.cnt_a !== 4'd1 || bus.cnt_b !== 4'd1)
         $display("FAIL sim_cnt: got cnt_a=%0d cnt_b=%0d expected 1/1", bus.cnt_a, bus.cnt_b); else pass_cnt++;
      bus.det_a = 1'b0; bus.det_b = 1'b0;
      tick(20);
      total_cnt++; if (bus.Ta !== 1'b0 || bus.Tb !== 1'b0)
         $display("FAIL sim_idle: got Ta=%b Tb=%b expected 0/0", bus.Ta, bus.Tb); else pass_cnt++;
      $display("simultaneous: Ta=%b Tb=%b cnt_a=%0d cnt_b=%0d", bus.Ta, bus.Tb, bus.cnt_a, bus.cnt_b);
   endtask

   task automatic test_reset_mid;
      bus.clr_b = 1'b1;
      tick(1);
      bus.clr_b = 1'b0;
      arrive(1'b1, 8, 8);
      arrive(1'b1, 8, 8);
      arrive(1'b1, 8, 8);                 // deb_b fell 2 cycles ago: b is in HOLD
      total_cnt++; if (bus.Tb !== 1'b1 || bus.cnt_b !== 4'd3)
         $display("FAIL mid_pre: got Tb=%b cnt_b=%0d expected 1/3", bus.Tb, bus.cnt_b); else pass_cnt++;
      bus.det_a = 1'b1;
      #2 reset = 1'b0;
      #1;
      total_cnt++; if (bus.Ta !== 1'b0 || bus.Tb !== 1'b0)
         $display("FAIL mid_t: got Ta=%b Tb=%b expected 0/0", bus.Ta, bus.Tb); else pass_cnt++;
      total_cnt++; if (bus.cnt_a !== 4'd0 || bus.cnt_b !== 4'd0)
         $display("FAIL mid_cnt: got cnt_a=%0d cnt_b=%0d expected 0/0", bus.cnt_a, bus.cnt_b); else pass_cnt++;
      tick(3);
      reset = 1'b1;                       // det_a already high: t
      tick(5);
      total_cnt++; if (bus.Ta !== 1'b0) $display("FAIL mid_ta_early: got %b expected 0", bus.Ta); else pass_cnt++;
      tick(1);
      total_cnt++; if (bus.Ta !== 1'b1) $display("FAIL mid_ta_rise: got %b expected 1", bus.Ta); else pass_cnt++;
      $display("reset_mid: Ta=%b Tb=%b cnt_a=%0d cnt_b=%0d", bus.Ta, bus.Tb, bus.cnt_a, bus.cnt_b);
      bus.det_a = 1'b0;
      tick(20);
   endtask

   task automatic test_stuck;
      bus.det_a = 1'b1;                   // t
`ifdef SENSOR_STUCK_DET_EN
      tick(1029);
      total_cnt++; if (bus.fault_a !== 1'b0) $display("FAIL stuck_early: got %b expected 0", bus.fault_a); else pass_cnt++;
      tick(1);                            // t+6+1024
      total_cnt++; if (bus.fault_a !== 1'b1) $display("FAIL stuck_set: got %b expected 1", bus.fault_a); else pass_cnt++;
      tick(70);
      bus.det_a = 1'b0;
      tick(40);
      total_cnt++; if (bus.Ta !== 1'b1 || bus.fault_a !== 1'b1)
         $display("FAIL stuck_hold: got Ta=%b fault_a=%b expected 1/1", bus.Ta, bus.fault_a); else pass_cnt++;
      total_cnt++; if (bus.fault_b !== 1'b0) $display("FAIL stuck_b: got %b expected 0", bus.fault_b); else pass_cnt++;
      reset = 1'b0;
      #1;
      total_cnt++; if (bus.fault_a !== 1'b0 || bus.Ta !== 1'b0)
         $display("FAIL stuck_rst: got fault_a=%b Ta=%b expected 0/0", bus.fault_a, bus.Ta); else pass_cnt++;
      tick(2);
      reset = 1'b1;
      tick(2);
`else
      tick(1100);
      total_cnt++; if (bus.fault_a !== 1'b0 || bus.Ta !== 1'b1)
         $display("FAIL nostuck_long: got fault_a=%b Ta=%b expected 0/1", bus.fault_a, bus.Ta); else pass_cnt++;
      bus.det_a = 1'b0;
      tick(14);                           // deb fall +6, hold 8
      total_cnt++; if (bus.Ta !== 1'b0 || bus.fault_a !== 1'b0)
         $display("FAIL nostuck_release: got Ta=%b fault_a=%b expected 0/0", bus.Ta, bus.fault_a); else pass_cnt++;
`endif
      $display("stuck: Ta=%b fault_a=%b fault_b=%b", bus.Ta, bus.fault_a, bus.fault_b);
   endtask

   initial begin
      test_reset();
      test_bounce();
      test_clean();
      test_rearrival();
      test_saturation();
      test_simultaneous();
      test_reset_mid();
      test_stuck();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
